// File: rtl/set_pkg.sv
// Shared definitions for the set counter job dispatcher: modes, FSM encoding,
// descriptor field layout.
package set_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_AND    = 2'b01;
  localparam logic [1:0] MODE_XOR    = 2'b10;
  localparam logic [1:0] MODE_RSV    = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_ACK   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int MODE_W    = 2;
  localparam int JOB_W     = CENTRAL_W + RADIUS_W + MODE_W;

  // central = {x1,y1,x2,y2,8'h00}, radius = {r1,r2,4'h0}
  localparam int CEN_X1_LSB = 20;
  localparam int CEN_Y1_LSB = 16;
  localparam int CEN_X2_LSB = 12;
  localparam int CEN_Y2_LSB = 8;
  localparam int RAD_R1_LSB = 8;
  localparam int RAD_R2_LSB = 4;

  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    logic [MODE_W-1:0]    mode;
  } job_t;

endpackage

// File: rtl/set_req_fifo.sv
// Request FIFO: power-of-two depth, registered ready derived from next occupancy.
module set_req_fifo
  import set_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = JOB_W + 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  output logic         push_ready,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          push, pop_ok;

  assign push   = push_valid && ready_q;
  assign pop_ok = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push) - CW'(pop_ok);
    ready_d  = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data   = mem_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign push_ready = ready_q;

endmodule

// File: rtl/set_job_dispatcher.sv
// Issues buffered jobs to the lattice-point set counter one at a time and
// returns the count (or a watchdog error) on a single-entry response slot.
module set_job_dispatcher
  import set_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_central,
  input  logic [11:0]      req_radius,
  input  logic [1:0]       req_mode,
  input  logic [TAG_W-1:0] req_tag,
  output logic             set_en,
  output logic [23:0]      set_central,
  output logic [11:0]      set_radius,
  output logic [1:0]       set_mode,
  input  logic             set_busy,
  input  logic             set_valid,
  input  logic [7:0]       set_candidate,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_candidate,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  localparam int FW   = JOB_W + TAG_W;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]       state_q, state_d;
  job_t             job_q, job_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WD_W-1:0]  wd_q, wd_d, wd_dec;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_cand_q, rsp_cand_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;

  logic          fifo_pop, fifo_empty;
  logic [FW-1:0] fifo_head;
  job_t          head_job;
  logic          slot_free, done, wd_zero, cap, cap_err;

  set_req_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (req_valid),
    .push_data  ({req_central, req_radius, req_mode, req_tag}),
    .push_ready (req_ready),
    .pop        (fifo_pop),
    .pop_data   (fifo_head),
    .empty      (fifo_empty)
  );

  assign head_job  = job_t'(fifo_head[FW-1:TAG_W]);
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign done      = set_valid && !set_busy;
  // Saturating countdown: expiry fires on the cycle the count lands on zero,
  // so the error response follows set_en by exactly TIMEOUT cycles.
  assign wd_dec    = (wd_q == '0) ? '0 : wd_q - 1'b1;
  assign wd_zero   = (wd_dec == '0);

  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    tag_d    = tag_q;
    wd_d     = wd_q;
    fifo_pop = 1'b0;
    cap      = 1'b0;
    cap_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          job_d    = head_job;
          tag_d    = fifo_head[TAG_W-1:0];
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = WD_W'(TIMEOUT - 1);
        state_d = ST_ACK;
      end
      ST_ACK: begin
        // A stale set_valid from the previous job is deliberately ignored here.
        wd_d = wd_dec;
        if (wd_zero && slot_free) begin
          cap     = 1'b1;
          cap_err = 1'b1;
          state_d = ST_DONE;
        end else if (set_busy) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wd_d = wd_dec;
        if (done && slot_free) begin
          cap     = 1'b1;
          state_d = ST_DONE;
        end else if (wd_zero && slot_free) begin
          cap     = 1'b1;
          cap_err = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_cand_d  = rsp_cand_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    if (cap) begin
      rsp_valid_d = 1'b1;
      rsp_cand_d  = cap_err ? 8'd0 : set_candidate;
      rsp_tag_d   = tag_q;
      rsp_err_d   = cap_err;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      job_q       <= '0;
      tag_q       <= '0;
      wd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_cand_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      tag_q       <= tag_d;
      wd_q        <= wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_cand_q  <= rsp_cand_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign set_en        = (state_q == ST_ISSUE);
  assign set_central   = job_q.central;
  assign set_radius    = job_q.radius;
  assign set_mode      = job_q.mode;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_candidate = rsp_cand_q;
  assign rsp_tag       = rsp_tag_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_set_job_dispatcher.sv
// Scoreboard bench: a behavioural lattice-point counter answers each job and
// expected responses are queued at request acceptance.
module tb_set_job_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_central = '0;
  logic [11:0] req_radius = '0;
  logic [1:0]  req_mode = '0;
  logic [3:0]  req_tag = '0;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy = 1'b0;
  logic        set_valid = 1'b0;
  logic [7:0]  set_candidate = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_candidate;
  logic [3:0]  rsp_tag;
  logic        rsp_err;

  set_job_dispatcher #(.DEPTH(4), .TAG_W(4), .TIMEOUT(512)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_central(req_central),
    .req_radius(req_radius), .req_mode(req_mode), .req_tag(req_tag),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
    .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
    .set_candidate(set_candidate),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_candidate(rsp_candidate),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tag;
    logic [7:0] cand;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   errs = 0;
  int   checks = 0;
  int   en_cnt = 0;
  int   cyc = 0;
  int   en_cyc = 0;
  int   val_cyc = 0;
  int   acc = 0;
  int   stall_at = -1;
  int   lat = 3;
  bit   hang = 1'b0;
  bit   prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_cnt(input logic [23:0] c, input logic [11:0] r,
                                 input logic [1:0] m);
    int x1, y1, x2, y2, r1, r2, n;
    bit a, b;
    x1 = int'(c[23:20]); y1 = int'(c[19:16]);
    x2 = int'(c[15:12]); y2 = int'(c[11:8]);
    r1 = int'(r[11:8]);  r2 = int'(r[7:4]);
    n = 0;
    for (int x = 1; x <= 8; x++)
      for (int y = 1; y <= 8; y++) begin
        a = ((x-x1)*(x-x1) + (y-y1)*(y-y1)) <= r1*r1;
        b = ((x-x2)*(x-x2) + (y-y2)*(y-y2)) <= r2*r2;
        case (m)
          2'b00: n += int'(a);
          2'b01: n += int'(a && b);
          2'b10: n += int'(a ^ b);
          default: n += 0;
        endcase
      end
    return n;
  endfunction

  // Counter model and response monitor, both evaluated away from the active edge.
  int  cm_cnt = 0;
  int  cm_res = 0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      set_busy = 1'b0; set_valid = 1'b0; set_candidate = '0; cm_cnt = 0;
    end else if (set_en) begin
      en_cnt++;
      en_cyc = cyc;
      set_valid = 1'b0;
      set_busy = !hang;
      cm_cnt = lat;
      cm_res = ref_cnt(set_central, set_radius, set_mode);
    end else if (set_busy) begin
      if (cm_cnt == 0) begin
        set_busy = 1'b0; set_valid = 1'b1; set_candidate = 8'(cm_res);
      end else cm_cnt--;
    end
    if (rsp_valid && !prev_valid) val_cyc = cyc;
    prev_valid = rsp_valid;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("unexp_rsp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        chk("rsp_cand", 32'(rsp_candidate), 32'(e.cand));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; leaves at posedge+1 after the handshake edge.
  task automatic send(input logic [23:0] c, input logic [11:0] r,
                      input logic [1:0] m, input logic [3:0] t);
    int n;
    exp_t e;
    req_valid = 1'b1; req_central = c; req_radius = r; req_mode = m; req_tag = t;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 3000) begin
      if (stall_at < 0) stall_at = acc;
      n++;
      @(negedge clk);
    end
    if (!req_ready) chk("req_timeout", 32'd0, 32'd1);
    else begin
      e.tag = t; e.err = hang;
      e.cand = hang ? 8'd0 : 8'(ref_cnt(c, r, m));
      exp_q.push_back(e);
      acc++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) chk(tag, 32'(exp_q.size()), 32'd0);
    step(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, n;
    step(3);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_set_en", 32'(set_en), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_outs", {set_central, set_radius[7:0]}, 32'd0);
    chk("rst_rsp", {rsp_candidate, rsp_tag, rsp_err, set_mode}, 32'd0);
    rst = 1'b0;
    step(2);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Single job, then AND / XOR / reserved modes.
    rsp_ready = 1'b1;
    e0 = en_cnt;
    send(24'h44_0000, 12'h300, 2'b00, 4'd3);
    drain("drain_single");
    chk("single_en_pulses", 32'(en_cnt - e0), 32'd1);
    send(24'h4444_00, 12'h330, 2'b01, 4'd4);
    send(24'h4444_00, 12'h330, 2'b10, 4'd5);
    send(24'h2266_00, 12'h540, 2'b11, 4'd6);
    send(24'h2366_00, 12'h440, 2'b10, 4'd7);
    drain("drain_modes");

    // Back-to-back burst against a slow counter: 4 queued + 1 in flight.
    lat = 40; acc = 0; stall_at = -1;
    for (int i = 0; i < 6; i++)
      send({4'(i + 1), 4'(8 - i), 4'd4, 4'd5, 8'h00}, 12'h320, 2'(i % 3), 4'(i));
    chk("burst_accept_before_stall", 32'(stall_at), 32'd5);
    drain("drain_burst");

    // Response backpressure longer than a counter job.
    lat = 5; rsp_ready = 1'b0; e0 = en_cnt;
    send(24'h44_0000, 12'h200, 2'b00, 4'd1);
    send(24'h55_0000, 12'h300, 2'b00, 4'd2);
    step(300);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rsp_tag", 32'(rsp_tag), 32'd1);
    chk("bp_en_count", 32'(en_cnt - e0), 32'd2);
    rsp_ready = 1'b1;
    drain("drain_bp");

    // Hung counter -> watchdog error, then a normal job.
    hang = 1'b1;
    send(24'h44_0000, 12'h300, 2'b00, 4'd9);
    drain("drain_hang");
    chk("wd_latency", 32'(val_cyc - en_cyc), 32'd512);
    hang = 1'b0; lat = 3;
    send(24'h33_0000, 12'h100, 2'b00, 4'd10);
    drain("drain_after_hang");

    // Reset while the counter is busy with one job and another is queued.
    lat = 50;
    send(24'h44_0000, 12'h300, 2'b00, 4'd11);
    send(24'h44_0000, 12'h200, 2'b00, 4'd12);
    n = 0;
    while (!set_busy && n < 100) begin n++; step(1); end
    chk("rst_test_busy", 32'(set_busy), 32'd1);
    step(5);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_outs", {set_central, set_mode, set_en, 6'd0}, 32'd0);
    exp_q.delete();
    step(3);
    rst = 1'b0;
    e0 = en_cnt;
    step(20);
    chk("postrst_fifo_empty", 32'(en_cnt - e0), 32'd0);
    chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
    lat = 3;
    send(24'h44_0000, 12'h300, 2'b00, 4'd13);
    drain("drain_postrst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
